// File: rtl/servo_frame_sequencer.sv
// Time-multiplexed servo PWM scheduler: NCH outputs share one µs prescaler and one slot
// counter, each channel pulsing once per frame inside its own fixed-length slot.
module servo_frame_sequencer #(
  parameter int unsigned TICK_DIV = 12,
  parameter int unsigned NCH      = 4,
  parameter int unsigned FRAME_US = 20000,
  parameter int unsigned SLOT_US  = 2500,
  parameter int unsigned MIN_US   = 1000,
  parameter int unsigned STEP_US  = 4,
  parameter int unsigned POS_RST  = 125
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           pos_wr,
  input  logic [2:0]     pos_ch,
  input  logic [7:0]     pos_data,
  output logic [NCH-1:0] servo,
  output logic           frame_start,
  output logic           busy
);

  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ChW   = $clog2(NCH);
  localparam int unsigned PadUs = FRAME_US - NCH * SLOT_US;

  typedef enum logic [1:0] {StIdle, StPulse, StGap, StPad} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [15:0]      us_q, us_d, us_inc, pulse_us;
  logic [ChW-1:0]   ch_q, ch_d;
  logic [NCH-1:0]   servo_q, servo_d;
  logic             frame_start_q, frame_start_d;
  logic             ena_q;
  logic [7:0]       shadow_q [NCH];
  logic [7:0]       active_q [NCH];
  logic             tick, wr_hit, start, frame_end;

  assign tick     = (presc_q == PW'(TICK_DIV - 1));
  assign us_inc   = us_q + 16'd1;
  assign pulse_us = 16'(MIN_US) + 16'(active_q[ch_q]) * 16'(STEP_US);
  assign wr_hit   = pos_wr && (32'(pos_ch) < NCH);

  always_comb begin
    state_d       = state_q;
    presc_d       = tick ? '0 : presc_q + PW'(1);
    us_d          = tick ? us_inc : us_q;
    ch_d          = ch_q;
    servo_d       = '0;
    frame_start_d = 1'b0;
    start         = 1'b0;
    frame_end     = 1'b0;

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        us_d    = '0;
        start   = ena_q;
      end
      StPulse: begin
        servo_d[ch_q] = 1'b1;
        if (tick && us_inc == pulse_us) begin
          servo_d = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (tick && us_inc == 16'(SLOT_US)) begin
          if (ch_q != ChW'(NCH - 1)) begin
            ch_d          = ch_q + ChW'(1);
            us_d          = '0;
            servo_d[ch_d] = 1'b1;
            state_d       = StPulse;
          end else if (PadUs == 0) begin
            frame_end = 1'b1;
          end else begin
            // Counter switches to frame-relative time for the padding interval.
            us_d    = 16'(NCH * SLOT_US);
            state_d = StPad;
          end
        end
      end
      StPad: begin
        frame_end = tick && (us_inc == 16'(FRAME_US));
      end
      default: state_d = StIdle;
    endcase

    if (frame_end) begin
      if (ena_q) begin
        start = 1'b1;
      end else begin
        state_d = StIdle;
        presc_d = '0;
        us_d    = '0;
        ch_d    = '0;
      end
    end

    if (start) begin
      state_d       = StPulse;
      presc_d       = '0;
      us_d          = '0;
      ch_d          = '0;
      servo_d       = '0;
      servo_d[0]    = 1'b1;
      frame_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      us_q          <= '0;
      ch_q          <= '0;
      servo_q       <= '0;
      frame_start_q <= 1'b0;
      ena_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      us_q          <= us_d;
      ch_q          <= ch_d;
      servo_q       <= servo_d;
      frame_start_q <= frame_start_d;
      ena_q         <= ena;
    end
  end

  // A write landing on the frame-start edge is forwarded straight into the active set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        shadow_q[c] <= 8'(POS_RST);
        active_q[c] <= 8'(POS_RST);
      end
    end else begin
      if (wr_hit) shadow_q[pos_ch[ChW-1:0]] <= pos_data;
      if (start) begin
        for (int c = 0; c < NCH; c++) begin
          active_q[c] <= (wr_hit && pos_ch == 3'(c)) ? pos_data : shadow_q[c];
        end
      end
    end
  end

  assign servo       = servo_q;
  assign frame_start = frame_start_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_servo_frame_sequencer.sv
// Randomized bench for servo_frame_sequencer, compared every cycle against a frame-offset
// model that derives each channel's pulse window directly from the timing rules.
module tb_servo_frame_sequencer;

  localparam int TD        = 2;
  localparam int NCH       = 4;
  localparam int FRAME_US  = 1100;
  localparam int SLOT_US   = 262;
  localparam int MIN_US    = 4;
  localparam int STEP_US   = 1;
  localparam int POS_RST   = 125;
  localparam int FRAME_CYC = FRAME_US * TD;
  localparam int SLOT_CYC  = SLOT_US * TD;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ena = 1'b0;
  logic           pos_wr = 1'b0;
  logic [2:0]     pos_ch = '0;
  logic [7:0]     pos_data = '0;
  logic [NCH-1:0] servo;
  logic           frame_start;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  servo_frame_sequencer #(
    .TICK_DIV(TD), .NCH(NCH), .FRAME_US(FRAME_US), .SLOT_US(SLOT_US),
    .MIN_US(MIN_US), .STEP_US(STEP_US), .POS_RST(POS_RST)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .pos_wr(pos_wr), .pos_ch(pos_ch),
    .pos_data(pos_data), .servo(servo), .frame_start(frame_start), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: frame running flag, cycle offset inside the frame, position sets.
  bit m_run, m_ena, m_new;
  int m_off;
  int m_shadow[NCH];
  int m_act[NCH];

  task automatic model_reset();
    m_run = 0; m_ena = 0; m_off = 0;
    for (int c = 0; c < NCH; c++) begin
      m_shadow[c] = POS_RST;
      m_act[c]    = POS_RST;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_new = 0;
        if (m_run) begin
          m_off++;
          if (m_off == FRAME_CYC) begin
            if (m_ena) m_new = 1;
            else m_run = 0;
          end
        end else if (m_ena) begin
          m_new = 1;
        end
        if (m_new) begin
          m_run = 1;
          m_off = 0;
          for (int c = 0; c < NCH; c++)
            m_act[c] = (pos_wr && int'(pos_ch) == c) ? int'(pos_data) : m_shadow[c];
        end
        if (pos_wr && int'(pos_ch) < NCH) m_shadow[pos_ch] = int'(pos_data);
        m_ena = ena;
      end
    end
  end

  always @(negedge clk) begin
    int exp_servo;
    int lo, hi;
    exp_servo = 0;
    if (m_run) begin
      for (int c = 0; c < NCH; c++) begin
        lo = c * SLOT_CYC;
        hi = lo + (MIN_US + m_act[c] * STEP_US) * TD;
        if (m_off >= lo && m_off < hi) exp_servo |= (1 << c);
      end
    end
    check("servo", int'(servo), exp_servo);
    check("frame_start", int'(frame_start), int'(m_run && m_off == 0));
    check("busy", int'(busy), int'(m_run));
    check("onehot", int'($onehot0(servo)), 1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_off(input int target, input int limit);
    int k = 0;
    while (!(m_run && m_off == target) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("wait_off", m_off, target);
  endtask

  task automatic write_pos(input int ch, input int data);
    pos_wr   = 1'b1;
    pos_ch   = 3'(ch);
    pos_data = 8'(data);
    @(negedge clk);
    pos_wr   = 1'b0;
  endtask

  initial begin
    cycles(3);
    check("reset_servo", int'(servo), 0);
    check("reset_busy", int'(busy), 0);
    ena = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("first_edge_idle", int'(busy), 0);
    @(negedge clk);
    check("second_edge_start", int'(frame_start), 1);
    check("second_edge_servo0", int'(servo), 1);

    // Default positions for one frame, then extremes for the next.
    wait_off(SLOT_CYC * 3, 3 * FRAME_CYC);
    write_pos(0, 0);
    write_pos(1, 255);
    wait_off(0, 3 * FRAME_CYC);

    // Mid-frame write only affects the following frame.
    wait_off(10, 3 * FRAME_CYC);
    write_pos(2, 0);

    // Write landing on the frame-start edge is bypassed into the new frame.
    wait_off(FRAME_CYC - 1, 3 * FRAME_CYC);
    write_pos(3, 200);
    wait_off(20, 3 * FRAME_CYC);
    write_pos(5, 77);
    wait_off(0, 3 * FRAME_CYC);

    // Enable drop during slot 1 completes the frame and goes idle.
    wait_off(SLOT_CYC + 5, 3 * FRAME_CYC);
    ena = 1'b0;
    cycles(2 * FRAME_CYC);
    check("idle_after_drop", int'(busy), 0);
    ena = 1'b1;
    cycles(2);
    check("restart_frame_start", int'(frame_start), 1);

    // Async reset while servo[1] is high.
    wait_off(SLOT_CYC + 20, 3 * FRAME_CYC);
    #2 rst = 1'b1;
    #1;
    check("async_rst_servo", int'(servo), 0);
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycles(FRAME_CYC + 10);

    // Random writes (including out-of-range channels) and occasional enable toggles.
    repeat (30000) begin
      @(negedge clk);
      pos_wr   = ($urandom_range(0, 49) == 0);
      pos_ch   = 3'($urandom_range(0, 7));
      pos_data = 8'($urandom);
      if ($urandom_range(0, 2999) == 0) ena = ~ena;
    end
    pos_wr = 1'b0;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
